magma_decrypt: RTL and testbench

- GOST R 34.12-2015 Magma (64-bit block, 256-bit key) single-block decryption core.
- Inverse-direction companion of the team's Magma encryption core. Shares its Feistel datapath style and its 3-phase round sequencing.
- Takes one 64-bit ciphertext block and returns the plaintext with a start/busy/done handshake.
- Sits on the receive side of the crypto path, after the ciphertext source and before the plaintext consumer.

---
 rtl/magma_decrypt.sv | 152 +++++++++++++++
 tb/tb_magma_decrypt.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/magma_decrypt.sv
// Magma (GOST R 34.12-2015) single-block decryptor, start/busy/done handshake.
// 3-phase rounds (latency 97); build option MAGMA_DEC_FAST_ROUND_EN gives one round per cycle (latency 33).
module magma_decrypt #(
   parameter int KEY_LATCH = 1
) (
   input  logic         clk,
   input  logic         reset_,
   input  logic         start,
   input  logic [63:0]  data_in,
   input  logic [255:0] key,
   output logic [63:0]  data_out,
   output logic         done,
   output logic         busy
);

   typedef enum logic [1:0] {ST_IDLE, ST_ROUND, ST_FINAL} state_t;

   // Packed so that PI[j] is table pi_j; entry v sits at nibble (15 - v).
   localparam logic [7:0][63:0] PI = {
      64'h17ed05834fa69cb2, 64'h8e25691cf4b0da37,
      64'h5df692cab78143e0, 64'h7f5a816d093eb42c,
      64'hc821d4f670a53e9b, 64'hb3582fade174c960,
      64'h68239a5c1e47bd0f, 64'hc462a5b9e8d703f1
   };

   function automatic logic [31:0] sbox(input logic [31:0] x);
      logic [31:0] y;
      y = '0;
      for (int j = 0; j < 8; j++) begin
         y[4*j +: 4] = PI[j][4*(15 - int'(x[4*j +: 4])) +: 4];
      end
      return y;
   endfunction

   function automatic logic [31:0] rotl11(input logic [31:0] x);
      return {x[20:0], x[31:21]};
   endfunction

   state_t        state_q, state_d;
   logic [31:0]   l_q, l_d, r_q, r_d;
   logic [4:0]    round_q, round_d;
   logic [63:0]   data_out_q, data_out_d;
   logic          done_q, done_d;
   logic [255:0]  key_q, key_d;
`ifndef MAGMA_DEC_FAST_ROUND_EN
   logic [31:0]   t_q, t_d;
   logic [1:0]    phase_q, phase_d;
`endif

   logic [255:0]  key_sel;
   logic [2:0]    kidx;
   logic [31:0]   rk;

   // Rounds 0..7 walk K1..K8, every later round walks K8..K1.
   assign key_sel = (KEY_LATCH != 0) ? key_q : key;
   assign kidx    = (round_q[4:3] == 2'b00) ? round_q[2:0] : ~round_q[2:0];
   assign rk      = key_sel[32*(7 - int'(kidx)) +: 32];

   always_comb begin
      state_d    = state_q;
      l_d        = l_q;
      r_d        = r_q;
      round_d    = round_q;
      data_out_d = data_out_q;
      done_d     = 1'b0;
      key_d      = key_q;
`ifndef MAGMA_DEC_FAST_ROUND_EN
      t_d        = t_q;
      phase_d    = phase_q;
`endif
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               l_d     = data_in[63:32];
               r_d     = data_in[31:0];
               round_d = 5'd0;
`ifndef MAGMA_DEC_FAST_ROUND_EN
               phase_d = 2'd0;
`endif
               if (KEY_LATCH != 0) key_d = key;
               state_d = ST_ROUND;
            end
         end
         ST_ROUND: begin
`ifdef MAGMA_DEC_FAST_ROUND_EN
            r_d     = l_q ^ rotl11(sbox(r_q + rk));
            l_d     = r_q;
            round_d = round_q + 5'd1;
            if (round_q == 5'd31) state_d = ST_FINAL;
`else
            case (phase_q)
               2'd0: begin
                  t_d     = r_q + rk;
                  phase_d = 2'd1;
               end
               2'd1: begin
                  t_d     = sbox(t_q);
                  phase_d = 2'd2;
               end
               default: begin
                  r_d     = l_q ^ rotl11(t_q);
                  l_d     = r_q;
                  round_d = round_q + 5'd1;
                  phase_d = 2'd0;
                  if (round_q == 5'd31) state_d = ST_FINAL;
               end
            endcase
`endif
         end
         ST_FINAL: begin
            // Every round swapped halves, so the output swap undoes the last one.
            data_out_d = {r_q, l_q};
            done_d     = 1'b1;
            state_d    = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_) begin
      if (!reset_) begin
         state_q    <= ST_IDLE;
         l_q        <= '0;
         r_q        <= '0;
         round_q    <= '0;
         data_out_q <= '0;
         done_q     <= 1'b0;
         key_q      <= '0;
`ifndef MAGMA_DEC_FAST_ROUND_EN
         t_q        <= '0;
         phase_q    <= '0;
`endif
      end else begin
         state_q    <= state_d;
         l_q        <= l_d;
         r_q        <= r_d;
         round_q    <= round_d;
         data_out_q <= data_out_d;
         done_q     <= done_d;
         key_q      <= key_d;
`ifndef MAGMA_DEC_FAST_ROUND_EN
         t_q        <= t_d;
         phase_q    <= phase_d;
`endif
      end
   end

   assign data_out = data_out_q;
   assign done     = done_q;
   assign busy     = (state_q != ST_IDLE);

endmodule

// File: tb/tb_magma_decrypt.sv
// Scoreboard bench for magma_decrypt: GOST vector, round trips, busy pokes, back-to-back, reset, live key.
module tb_magma_decrypt;

`ifdef MAGMA_DEC_FAST_ROUND_EN
   localparam int LAT    = 33;
   localparam int POKE   = 14;
   localparam int RST_AT = 17;
`else
   localparam int LAT    = 97;
   localparam int POKE   = 40;
   localparam int RST_AT = 50;
`endif

   localparam logic [255:0] VEC_KEY = 256'hffeeddccbbaa99887766554433221100f0f1f2f3f4f5f6f7f8f9fafbfcfdfeff;
   localparam logic [63:0]  VEC_CT  = 64'h4ee901e5c2d8ca3d;
   localparam logic [63:0]  VEC_PT  = 64'hfedcba9876543210;

   localparam logic [3:0] TBL [8][16] = '{
      '{12, 4, 6, 2,10, 5,11, 9,14, 8,13, 7, 0, 3,15, 1},
      '{ 6, 8, 2, 3, 9,10, 5,12, 1,14, 4, 7,11,13, 0,15},
      '{11, 3, 5, 8, 2,15,10,13,14, 1, 7, 4,12, 9, 6, 0},
      '{12, 8, 2, 1,13, 4,15, 6, 7, 0,10, 5, 3,14, 9,11},
      '{ 7,15, 5,10, 8, 1, 6,13, 0, 9, 3,14,11, 4, 2,12},
      '{ 5,13,15, 6, 9, 2,12,10,11, 7, 8, 1, 4, 3,14, 0},
      '{ 8,14, 2, 5, 6, 9, 1,12,15, 4,11, 0,13,10, 3, 7},
      '{ 1, 7,14,13, 0, 5, 8, 3, 4,15,10, 6, 9,12,11, 2}
   };

   logic         clk = 1'b0;
   logic         reset_ = 1'b0;
   logic         start = 1'b0;
   logic         start0 = 1'b0;
   logic [63:0]  data_in = '0;
   logic [255:0] key = '0;
   logic [255:0] key0 = '0;
   logic [63:0]  data_out, data_out0;
   logic         done, done0, busy, busy0;

   int total = 0;
   int bad = 0;
   int cyc = 0;
   int n_done = 0;
   logic done_prev = 1'b0;

   typedef struct {
      logic [63:0] dat;
      int          acc;
   } sb_t;
   sb_t exp_q[$];

   magma_decrypt #(.KEY_LATCH(1)) dut (
      .clk(clk), .reset_(reset_), .start(start), .data_in(data_in), .key(key),
      .data_out(data_out), .done(done), .busy(busy)
   );

   magma_decrypt #(.KEY_LATCH(0)) dut0 (
      .clk(clk), .reset_(reset_), .start(start0), .data_in(data_in), .key(key0),
      .data_out(data_out0), .done(done0), .busy(busy0)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%h exp=%h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   function automatic logic [31:0] gfn(input logic [31:0] x, input logic [31:0] k);
      logic [31:0] t, s;
      t = x + k;
      for (int j = 0; j < 8; j++) s[4*j +: 4] = TBL[j][t[4*j +: 4]];
      return {s[20:0], s[31:21]};
   endfunction

   function automatic logic [63:0] feistel(input logic [63:0] blk, input logic [255:0] k, input bit decrypt);
      logic [31:0] a, b, n;
      int idx;
      a = blk[63:32];
      b = blk[31:0];
      for (int i = 0; i < 32; i++) begin
         if (decrypt) idx = (i < 8)  ? i : 7 - (i % 8);
         else         idx = (i < 24) ? (i % 8) : 7 - (i % 8);
         n = a ^ gfn(b, k[255 - 32*idx -: 32]);
         a = b;
         b = n;
      end
      return {b, a};
   endfunction

   // Scoreboard: every done must match the oldest outstanding block.
   always @(negedge clk) begin
      if (reset_ && done) begin
         chk("done_one_cycle", {63'd0, done_prev}, 64'd0);
         if (exp_q.size() == 0) begin
            chk("unexpected_done", {63'd0, done}, 64'd0);
         end else begin
            sb_t e;
            e = exp_q.pop_front();
            chk("data_out", data_out, e.dat);
            chk("latency", 64'(cyc - e.acc), 64'(LAT));
         end
         n_done++;
      end
      done_prev = done;
   end

   task automatic wait_until(input int c);
      while (cyc < c) @(negedge clk);
   endtask

   task automatic launch(input logic [63:0] d, input logic [255:0] k, input logic [63:0] e, output int acc);
      data_in = d;
      key = k;
      start = 1'b1;
      acc = cyc + 1;
      exp_q.push_back('{e, acc});
      @(negedge clk);
      start = 1'b0;
   endtask

   initial begin
      int a, a2, n0, got;
      logic [255:0] rk;
      logic [63:0]  rp;

      repeat (3) @(negedge clk);
      chk("rst_data_out", data_out, 64'd0);
      chk("rst_done", {63'd0, done}, 64'd0);
      chk("rst_busy", {63'd0, busy}, 64'd0);
      chk("rst_busy_kl0", {63'd0, busy0}, 64'd0);
      reset_ = 1'b1;
      repeat (2) @(negedge clk);

      // GOST reference vector
      launch(VEC_CT, VEC_KEY, VEC_PT, a);
      chk("vec_busy", {63'd0, busy}, 64'd1);
      wait_until(a + LAT - 1);
      chk("vec_not_early", {63'd0, done}, 64'd0);
      wait_until(a + LAT + 1);
      chk("vec_done_clear", {63'd0, done}, 64'd0);
      chk("vec_busy_clear", {63'd0, busy}, 64'd0);
      chk("vec_drain", 64'(exp_q.size()), 64'd0);

      // start, data and key disturbed mid-run
      n0 = n_done;
      launch(VEC_CT, VEC_KEY, VEC_PT, a);
      wait_until(a + POKE - 1);
      data_in = '0;
      key = '0;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_until(a + LAT + 3);
      chk("poke_one_done", 64'(n_done - n0), 64'd1);
      chk("poke_drain", 64'(exp_q.size()), 64'd0);

      // back-to-back with start held high
      n0 = n_done;
      data_in = VEC_CT;
      key = VEC_KEY;
      start = 1'b1;
      a = cyc + 1;
      exp_q.push_back('{VEC_PT, a});
      @(negedge clk);
      data_in = '0;
      key = '0;
      exp_q.push_back('{feistel(64'd0, 256'd0, 1'b1), a + LAT + 1});
      wait_until(a + LAT + 1 + LAT / 2);
      chk("b2b_hold", data_out, VEC_PT);
      chk("b2b_busy2", {63'd0, busy}, 64'd1);
      start = 1'b0;
      wait_until(a + 2 * (LAT + 1) + 2);
      chk("b2b_two_done", 64'(n_done - n0), 64'd2);
      chk("b2b_drain", 64'(exp_q.size()), 64'd0);

      // round trip against the encryption direction
      for (int i = 0; i < 20; i++) begin
         rk = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
         rp = {$urandom, $urandom};
         launch(feistel(rp, rk, 1'b0), rk, rp, a);
         wait_until(a + LAT + 1);
      end
      chk("rt_drain", 64'(exp_q.size()), 64'd0);

      // reset mid-operation
      launch(VEC_CT, VEC_KEY, VEC_PT, a);
      wait_until(a + RST_AT);
      reset_ = 1'b0;
      exp_q.delete();
      #1;
      chk("midrst_data_out", data_out, 64'd0);
      chk("midrst_done", {63'd0, done}, 64'd0);
      chk("midrst_busy", {63'd0, busy}, 64'd0);
      @(negedge clk);
      reset_ = 1'b1;
      n0 = n_done;
      repeat (LAT + 3) @(negedge clk);
      chk("midrst_no_stale", 64'(n_done - n0), 64'd0);
      launch(VEC_CT, VEC_KEY, VEC_PT, a2);
      wait_until(a2 + LAT + 1);
      chk("midrst_drain", 64'(exp_q.size()), 64'd0);

      // live key, held stable
      data_in = VEC_CT;
      key0 = VEC_KEY;
      start0 = 1'b1;
      a = cyc + 1;
      @(negedge clk);
      start0 = 1'b0;
      got = -1;
      for (int i = 0; i < LAT + 5 && got < 0; i++) begin
         @(negedge clk);
         if (done0) got = cyc;
      end
      chk("kl0_latency", 64'(got - a), 64'(LAT));
      chk("kl0_data", data_out0, VEC_PT);

      // live key, flipped mid-run
      start0 = 1'b1;
      a = cyc + 1;
      @(negedge clk);
      start0 = 1'b0;
      wait_until(a + 10);
      key0 = '0;
      got = -1;
      for (int i = 0; i < LAT + 5 && got < 0; i++) begin
         @(negedge clk);
         if (done0) got = cyc;
      end
      chk("kl0_flip_done", 64'(got - a), 64'(LAT));
      chk("kl0_flip_differs", {63'd0, data_out0 != VEC_PT}, 64'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
